// File: rtl/rat_flag_if.sv
// Bundle of control, ALU and status signals between the RAT control unit,
// the ALU and the flag unit.
interface rat_flag_if;
    logic       ALU_C;
    logic       ALU_Z;
    logic       FLG_C_LD;
    logic       FLG_Z_LD;
    logic       FLG_LD_SEL;
    logic       FLG_C_SET;
    logic       FLG_C_CLR;
    logic       FLG_SHAD_LD;
    logic       I_SET;
    logic       I_CLR;
    logic       INTR_IN;
    logic       INTR_ACK;
    logic [2:0] BR_COND;
    logic       C_FLAG;
    logic       Z_FLAG;
    logic       I_FLAG;
    logic       INTR_REQ;
    logic       BR_TAKE;

    modport master (
        output ALU_C, ALU_Z, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_C_SET, FLG_C_CLR,
               FLG_SHAD_LD, I_SET, I_CLR, INTR_IN, INTR_ACK, BR_COND,
        input  C_FLAG, Z_FLAG, I_FLAG, INTR_REQ, BR_TAKE
    );

    modport slave (
        input  ALU_C, ALU_Z, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_C_SET, FLG_C_CLR,
               FLG_SHAD_LD, I_SET, I_CLR, INTR_IN, INTR_ACK, BR_COND,
        output C_FLAG, Z_FLAG, I_FLAG, INTR_REQ, BR_TAKE
    );
endinterface

// File: rtl/rat_flag_unit.sv
// RAT status flags (C, Z, I), ISR shadow copies, branch evaluation and
// synchronised, edge-detected interrupt request generation.
module rat_flag_unit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_I     = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    rat_flag_if.slave   bus
);

    function automatic logic br_decide(input logic [2:0] cond, input logic c, input logic z);
        logic take;
        case (cond)
            3'b000:  take = 1'b1;
            3'b001:  take = c;
            3'b010:  take = ~c;
            3'b011:  take = z;
            3'b100:  take = ~z;
            default: take = 1'b0;
        endcase
        return take;
    endfunction

    logic                   r_c;
    logic                   r_z;
    logic                   r_i;
    logic                   r_req;
    logic                   r_shad_c;
    logic                   r_shad_z;
    logic                   r_edge_d;
    logic [SYNC_STAGES-1:0] r_sync;

    logic w_c_src;
    logic w_z_src;
    logic w_sync_out;
    logic w_rise;

    // Load-source mux: ALU results normally, shadow copies on return from ISR
    always_comb begin
        w_c_src = 1'b0;
        w_z_src = 1'b0;
        if (bus.FLG_LD_SEL) begin
            w_c_src = r_shad_c;
            w_z_src = r_shad_z;
        end else begin
            w_c_src = bus.ALU_C;
            w_z_src = bus.ALU_Z;
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_edge_d;

    // Architectural C and Z flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
        end else begin
            if (bus.FLG_C_CLR) begin
                r_c <= 1'b0;
            end else if (bus.FLG_C_SET) begin
                r_c <= 1'b1;
            end else if (bus.FLG_C_LD) begin
                r_c <= w_c_src;
            end else begin
                r_c <= r_c;
            end
            if (bus.FLG_Z_LD) begin
                r_z <= w_z_src;
            end else begin
                r_z <= r_z;
            end
        end
    end

    // Shadow copies take the pre-edge flags, so a same-cycle load is not seen
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else if (bus.FLG_SHAD_LD || bus.INTR_ACK) begin
            r_shad_c <= r_c;
            r_shad_z <= r_z;
        end else begin
            r_shad_c <= r_shad_c;
            r_shad_z <= r_shad_z;
        end
    end

    // Interrupt enable flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_i <= RESET_I;
        end else if (bus.INTR_ACK || bus.I_CLR) begin
            r_i <= 1'b0;
        end else if (bus.I_SET) begin
            r_i <= 1'b1;
        end else begin
            r_i <= r_i;
        end
    end

    // INTR_IN synchroniser chain followed by the edge-detect flop
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync   <= '0;
            r_edge_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.INTR_IN};
            r_edge_d <= w_sync_out;
        end
    end

    // Held request: ACK beats a coincident edge; masked edges are dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_req <= 1'b0;
        end else if (bus.INTR_ACK) begin
            r_req <= 1'b0;
        end else if (w_rise && r_i) begin
            r_req <= 1'b1;
        end else begin
            r_req <= r_req;
        end
    end

    assign bus.C_FLAG   = r_c;
    assign bus.Z_FLAG   = r_z;
    assign bus.I_FLAG   = r_i;
    assign bus.INTR_REQ = r_req;
    assign bus.BR_TAKE  = br_decide(bus.BR_COND, r_c, r_z);

endmodule
